// File: rtl/mbc_pkg.sv
// mbc_pkg: write-strobe FSM states, register region decodes and RAM enable key for mbc5_sync.
package mbc_pkg;
    typedef enum logic [1:0] {IDLE, LOW_CNT, ARMED, COMMIT} wr_state_e;
    localparam logic [2:0] REG_RAMEN = 3'b000;
    localparam logic [3:0] REG_ROMLO = 4'b0010;
    localparam logic [3:0] REG_ROMHI = 4'b0011;
    localparam logic [2:0] REG_RAMB  = 3'b010;
    localparam logic [3:0] RAM_KEY   = 4'hA;
endpackage

// File: rtl/mbc5_sync_if.sv
// mbc5_sync_if: Game Boy cartridge-edge bus plus the banked ROM/SRAM side of the controller.
interface mbc5_sync_if #(
    parameter int ROM_BANK_BITS = 9,
    parameter int RAM_BANK_BITS = 4
);
    logic [3:0]               gb_addr;
    logic [7:0]               gb_data;
    logic                     gb_write_n;
    logic                     gb_read_n;
    logic                     gb_cs_n;
    logic [ROM_BANK_BITS-1:0] rom_a;
    logic [RAM_BANK_BITS-1:0] ram_a;
    logic                     rom_cs_n;
    logic                     ram_cs_n;
    logic                     rumble;
    logic                     wr_reject;
    modport master (
        output gb_addr, gb_data, gb_write_n, gb_read_n, gb_cs_n,
        input  rom_a, ram_a, rom_cs_n, ram_cs_n, rumble, wr_reject
    );
    modport slave (
        input  gb_addr, gb_data, gb_write_n, gb_read_n, gb_cs_n,
        output rom_a, ram_a, rom_cs_n, ram_cs_n, rumble, wr_reject
    );
endinterface

// File: rtl/mbc_wr_strobe.sv
// mbc_wr_strobe: synchronises gb_write_n, filters short strobes and emits one commit pulse per accepted write.
module mbc_wr_strobe
    import mbc_pkg::*;
#(
    parameter int MIN_WR_LOW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       write_n_i,
    input  logic [3:0] addr_i,
    input  logic [7:0] data_i,
    output logic       commit_o,
    output logic [3:0] addr_o,
    output logic [7:0] data_o,
    output logic       wr_reject_o
);
    localparam int CW = $clog2(MIN_WR_LOW + 1);
    wr_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          s1_q, wr_s_q, rej_q, rej_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b1;
            wr_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rej_q   <= 1'b0;
        end else begin
            s1_q    <= write_n_i;
            wr_s_q  <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rej_q   <= rej_d;
        end
    end
    // Address/data are sampled only once the strobe has been low long enough to be settled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rej_d   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = wr_s_q ? IDLE : LOW_CNT;
                cnt_d   = wr_s_q ? cnt_q : CW'(1);
            end
            LOW_CNT: begin
                if (cnt_q == CW'(MIN_WR_LOW)) begin
                    addr_d  = addr_i;
                    data_d  = data_i;
                    state_d = ARMED;
                end else if (wr_s_q) begin
                    state_d = IDLE;
                    rej_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARMED:   state_d = wr_s_q ? COMMIT : ARMED;
            default: state_d = IDLE;
        endcase
    end
    assign commit_o    = state_q == COMMIT;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign wr_reject_o = rej_q;
endmodule

// File: rtl/mbc5_sync.sv
// mbc5_sync: clocked MBC5 bank controller; bank/enable registers commit on a filtered write pulse.
module mbc5_sync
    import mbc_pkg::*;
#(
    parameter int ROM_BANK_BITS = 9,
    parameter int RAM_BANK_BITS = 4,
    parameter int RUMBLE_EN     = 0,
    parameter int MIN_WR_LOW    = 3
) (
    input logic        clk,
    input logic        rst,
    mbc5_sync_if.slave bus
);
    logic [ROM_BANK_BITS-1:0] rom_bank_q, rom_bank_d;
    logic [RAM_BANK_BITS-1:0] ram_bank_q, ram_bank_d;
    logic                     ram_en_q, ram_en_d;
    logic                     commit, wr_reject;
    logic [3:0]               h_addr;
    logic [7:0]               h_data;
    logic [8:0]               rb_full, rb_next;
    mbc_wr_strobe #(.MIN_WR_LOW(MIN_WR_LOW)) u_wr (
        .clk         (clk),
        .rst         (rst),
        .write_n_i   (bus.gb_write_n),
        .addr_i      (bus.gb_addr),
        .data_i      (bus.gb_data),
        .commit_o    (commit),
        .addr_o      (h_addr),
        .data_o      (h_data),
        .wr_reject_o (wr_reject)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_bank_q <= ROM_BANK_BITS'(1);
            ram_bank_q <= '0;
            ram_en_q   <= 1'b0;
        end else begin
            rom_bank_q <= rom_bank_d;
            ram_bank_q <= ram_bank_d;
            ram_en_q   <= ram_en_d;
        end
    end
    // The bank is widened to 9 bits so the high-bit write simply truncates away on narrower ROMs.
    always_comb begin
        rb_full    = 9'(rom_bank_q);
        rb_next    = rb_full;
        ram_bank_d = ram_bank_q;
        ram_en_d   = ram_en_q;
        if (commit) begin
            if (h_addr[3:1] == REG_RAMEN) ram_en_d = h_data[3:0] == RAM_KEY;
            else if (h_addr == REG_ROMLO) rb_next = {rb_full[8], h_data};
            else if (h_addr == REG_ROMHI) rb_next = {h_data[0], rb_full[7:0]};
            else if (h_addr[3:1] == REG_RAMB) ram_bank_d = h_data[RAM_BANK_BITS-1:0];
        end
        rom_bank_d = rb_next[ROM_BANK_BITS-1:0];
    end
    assign bus.rom_a     = bus.gb_addr[2] ? rom_bank_q : '0;
    assign bus.ram_a     = ram_bank_q & ~RAM_BANK_BITS'((RUMBLE_EN != 0) ? 8 : 0);
    assign bus.rumble    = (RUMBLE_EN != 0) & ram_bank_q[RAM_BANK_BITS-1];
    assign bus.rom_cs_n  = bus.gb_addr[3] | bus.gb_read_n | rst;
    assign bus.ram_cs_n  = ~(ram_en_q & ~bus.gb_cs_n & (bus.gb_addr[3:1] == 3'b101));
    assign bus.wr_reject = wr_reject;
endmodule

// File: tb/tb_mbc5_sync.sv
// tb_mbc5_sync: randomized scoreboard bench for mbc5_sync against a register-level model of the mapper.
module tb_mbc5_sync;
    localparam int RBB = 9, RAB = 4, RUM = 1, MINW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mbc5_sync_if #(.ROM_BANK_BITS(RBB), .RAM_BANK_BITS(RAB)) bus ();
    mbc5_sync #(.ROM_BANK_BITS(RBB), .RAM_BANK_BITS(RAB), .RUMBLE_EN(RUM), .MIN_WR_LOW(MINW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    typedef struct {
        string name;
        int    rom_a;
        int    ram_a;
        int    rumble;
        int    rom_cs_n;
        int    ram_cs_n;
    } exp_t;
    exp_t  exp_q[$];
    string rej_q[$];
    int    checks = 0, errors = 0;
    bit    probe = 1'b0;
    int    m_rom = 1, m_ram = 0, m_en = 0;
    task automatic chk(input string n, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask
    task automatic model_reset();
        m_rom = 1;
        m_ram = 0;
        m_en  = 0;
    endtask
    task automatic model_write(input int a, input int d);
        if ((a >> 1) == 0) m_en = ((d & 15) == 10) ? 1 : 0;
        else if (a == 2) m_rom = (m_rom & 256) | d;
        else if (a == 3) m_rom = (m_rom & 255) | ((d & 1) << 8);
        else if ((a >> 1) == 2) m_ram = d & 15;
    endtask
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic do_probe(input string n);
        exp_t e;
        int a;
        a = int'(bus.gb_addr);
        e.name     = n;
        e.rom_a    = ((a >> 2) & 1) != 0 ? m_rom : 0;
        e.ram_a    = m_ram & 7;
        e.rumble   = (m_ram >> 3) & 1;
        e.rom_cs_n = (((a >> 3) & 1) != 0 || bus.gb_read_n || rst) ? 1 : 0;
        e.ram_cs_n = (m_en != 0 && !bus.gb_cs_n && (a >> 1) == 5) ? 0 : 1;
        exp_q.push_back(e);
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask
    task automatic do_write(input int a, input int d, input int l, input bit lat, input string n);
        bus.gb_addr    = 4'(a);
        bus.gb_data    = 8'(d);
        bus.gb_read_n  = 1'b1;
        bus.gb_write_n = 1'b0;
        repeat (l) step();
        bus.gb_write_n = 1'b1;
        if (l < MINW) rej_q.push_back(n);
        repeat (3) step();
        bus.gb_addr   = 4'h4;
        bus.gb_read_n = 1'b0;
        if (lat) begin
            do_probe({n, "_edge3"});
            if (l >= MINW) model_write(a, d);
            do_probe({n, "_edge4"});
        end else begin
            if (l >= MINW) model_write(a, d);
            repeat (5) step();
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (probe) begin
            if (exp_q.size() == 0) chk("probe_queue_empty", 32'(0), 1);
            else begin
                e = exp_q.pop_front();
                chk({e.name, ".rom_a"}, 32'(bus.rom_a), e.rom_a);
                chk({e.name, ".ram_a"}, 32'(bus.ram_a), e.ram_a);
                chk({e.name, ".rumble"}, 32'(bus.rumble), e.rumble);
                chk({e.name, ".rom_cs_n"}, 32'(bus.rom_cs_n), e.rom_cs_n);
                chk({e.name, ".ram_cs_n"}, 32'(bus.ram_cs_n), e.ram_cs_n);
            end
        end
        if (bus.wr_reject !== 1'b0) begin
            if (rej_q.size() == 0) chk("unexpected_wr_reject", 32'(bus.wr_reject), 0);
            else begin
                void'(rej_q.pop_front());
                checks++;
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int a, d, l;
        bus.gb_addr    = 4'h0;
        bus.gb_data    = 8'h00;
        bus.gb_write_n = 1'b1;
        bus.gb_read_n  = 1'b0;
        bus.gb_cs_n    = 1'b1;
        step();
        step();
        do_probe("rst_held");
        rst = 1'b0;
        repeat (2) step();
        bus.gb_addr = 4'h0;
        do_probe("rst_a14lo");
        bus.gb_addr = 4'h4;
        do_probe("rst_a14hi");
        bus.gb_addr = 4'hA;
        bus.gb_cs_n = 1'b0;
        do_probe("rst_ram");
        do_write(2, 'h37, 5, 1'b1, "romlo");
        do_write(3, 'h01, 5, 1'b1, "romhi");
        do_write(0, 'h0A, 5, 1'b0, "ramen");
        bus.gb_addr = 4'hA;
        bus.gb_cs_n = 1'b0;
        do_probe("ram_on");
        do_write(0, 'h00, 5, 1'b0, "ramdis");
        bus.gb_addr = 4'hA;
        do_probe("ram_off");
        do_write(4, 'h0B, 5, 1'b0, "rumble");
        do_probe("rumble");
        do_write(2, 'h55, 2, 1'b0, "short");
        do_probe("short");
        bus.gb_addr    = 4'h2;
        bus.gb_data    = 8'h22;
        bus.gb_write_n = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        model_reset();
        bus.gb_addr = 4'h4;
        do_probe("rst_armed_hold");
        bus.gb_write_n = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (8) step();
        do_probe("rst_armed_after");
        bus.gb_addr    = 4'h2;
        bus.gb_data    = 8'h44;
        bus.gb_write_n = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        repeat (6) step();
        bus.gb_write_n = 1'b1;
        repeat (3) step();
        model_write(2, 'h44);
        bus.gb_addr = 4'h4;
        repeat (5) step();
        do_probe("rst_low_release");
        bus.gb_addr    = 4'h2;
        bus.gb_data    = 8'h99;
        bus.gb_write_n = 1'b0;
        repeat (20) step();
        bus.gb_addr = 4'h4;
        do_probe("long_low");
        bus.gb_write_n = 1'b1;
        repeat (3) step();
        model_write(2, 'h99);
        repeat (5) step();
        do_probe("long_done");
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 255));
            l = int'($urandom_range(1, 7));
            do_write(a, d, l, 1'b0, "rnd");
            bus.gb_addr   = 4'($urandom_range(0, 15));
            bus.gb_read_n = 1'($urandom_range(0, 1));
            bus.gb_cs_n   = 1'($urandom_range(0, 1));
            do_probe("rnd_pins");
            bus.gb_addr   = 4'h4;
            bus.gb_read_n = 1'b0;
            do_probe("rnd_rom");
            bus.gb_addr = 4'hA;
            bus.gb_cs_n = 1'b0;
            do_probe("rnd_ram");
        end
        repeat (4) step();
        chk("reject_queue_drained", 32'(rej_q.size()), 0);
        chk("probe_queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
